// File: rtl/time_set_if.sv
// Push-button inputs and counter-control outputs of the wall-clock time-set front end.
interface time_set_if;
    logic btn_mode;
    logic btn_inc;
    logic enable;
    logic setting_enable;
    logic set_hr_or_min;
    logic inc_short;

    modport master (
        output btn_mode,
        output btn_inc,
        input  enable,
        input  setting_enable,
        input  set_hr_or_min,
        input  inc_short
    );

    modport slave (
        input  btn_mode,
        input  btn_inc,
        output enable,
        output setting_enable,
        output set_hr_or_min,
        output inc_short
    );
endinterface

// File: rtl/time_set_controller.sv
// Button synchronizer/debouncer, short/long press classifier, run/set mode FSM
// and increment pulse generator with auto-repeat for the wall-clock counter.
module time_set_controller #(
    parameter int DEBOUNCE_TICKS = 200,
    parameter int LONG_TICKS     = 10000,
    parameter int REPEAT_TICKS   = 2000
) (
    input  logic       clk_10000Hz,
    input  logic       rst_n,
    time_set_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    // Per-button vectors: bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    deb_r;
    logic [1:0]    deb_d_r;
    logic [1:0]    long_done_r;
    logic [1:0]    short_r;
    logic [DW-1:0] deb_cnt_r [2];
    logic [LW-1:0] hold_cnt_r [2];
    logic [1:0]    rise_s;
    logic [1:0]    fall_s;
    logic [1:0]    long_s;

    logic          mode_long_r;
    logic          mode_short_r;
    state_t        state_r;
    state_t        next_state_s;
    logic          change_s;
    logic          in_set_s;
    logic          armed_r;
    logic [RW-1:0] rep_cnt_r;
    logic          rep_fire_s;
    logic          inc_pulse_s;
    logic          enable_s;
    logic          setting_enable_s;
    logic          set_hr_or_min_s;
    logic          enable_r;
    logic          setting_enable_r;
    logic          set_hr_or_min_r;
    logic          inc_short_r;

    assign raw_s = {bus.btn_inc, bus.btn_mode};

    // Debounced edge detection and single-shot long event per button
    always_comb begin
        rise_s = 2'b00;
        fall_s = 2'b00;
        long_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rise_s[i] = deb_r[i] & ~deb_d_r[i];
            fall_s[i] = ~deb_r[i] & deb_d_r[i];
            long_s[i] = (hold_cnt_r[i] == LONG_MAX) & ~long_done_r[i];
        end
    end

    // Synchronizers, debouncers, hold timers and press classification
    always_ff @(posedge clk_10000Hz) begin
        if (!rst_n) begin
            sync1_r     <= 2'b00;
            sync2_r     <= 2'b00;
            deb_r       <= 2'b00;
            deb_d_r     <= 2'b00;
            long_done_r <= 2'b00;
            short_r     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i]  <= '0;
                hold_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                end
                if (!deb_r[i]) begin
                    hold_cnt_r[i] <= '0;
                end else if (hold_cnt_r[i] != LONG_MAX) begin
                    hold_cnt_r[i] <= hold_cnt_r[i] + LW'(1);
                end else begin
                    hold_cnt_r[i] <= hold_cnt_r[i];
                end
                long_done_r[i] <= deb_r[i] & (long_done_r[i] | long_s[i]);
                // Hold count is still valid in the cycle after the fall; it clears one edge later.
                short_r[i]     <= fall_s[i] & (hold_cnt_r[i] != LONG_MAX);
            end
        end
    end

    // Mode FSM state register and registered mode events
    always_ff @(posedge clk_10000Hz) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            mode_long_r  <= 1'b0;
            mode_short_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            mode_long_r  <= long_s[0];
            mode_short_r <= short_r[0];
        end
    end

    // Mode FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mode_long_r) next_state_s = ST_SET_HR;
                else             next_state_s = ST_RUN;
            end
            ST_SET_HR: begin
                if (mode_long_r)       next_state_s = ST_RUN;
                else if (mode_short_r) next_state_s = ST_SET_MIN;
                else                   next_state_s = ST_SET_HR;
            end
            ST_SET_MIN: begin
                if (mode_long_r)       next_state_s = ST_RUN;
                else if (mode_short_r) next_state_s = ST_SET_HR;
                else                   next_state_s = ST_SET_MIN;
            end
            default: next_state_s = ST_RUN;
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track the state register
    always_comb begin
        enable_s         = 1'b1;
        setting_enable_s = 1'b0;
        set_hr_or_min_s  = 1'b0;
        case (next_state_s)
            ST_RUN: begin
                enable_s         = 1'b1;
                setting_enable_s = 1'b0;
                set_hr_or_min_s  = 1'b0;
            end
            ST_SET_HR: begin
                enable_s         = 1'b0;
                setting_enable_s = 1'b1;
                set_hr_or_min_s  = 1'b0;
            end
            ST_SET_MIN: begin
                enable_s         = 1'b0;
                setting_enable_s = 1'b1;
                set_hr_or_min_s  = 1'b1;
            end
            default: begin
                enable_s         = 1'b1;
                setting_enable_s = 1'b0;
                set_hr_or_min_s  = 1'b0;
            end
        endcase
    end

    // Increment pulse request; a mode transition in the same cycle wins
    always_comb begin
        in_set_s    = (state_r != ST_RUN);
        change_s    = (next_state_s != state_r);
        rep_fire_s  = long_done_r[1] & deb_r[1] & (rep_cnt_r == REP_LAST);
        inc_pulse_s = 1'b0;
        if (in_set_s && !change_s) begin
            inc_pulse_s = rise_s[1] | (armed_r & (long_s[1] | rep_fire_s));
        end else begin
            inc_pulse_s = 1'b0;
        end
    end

    // Arming, auto-repeat counter and registered outputs
    always_ff @(posedge clk_10000Hz) begin
        if (!rst_n) begin
            armed_r          <= 1'b0;
            rep_cnt_r        <= '0;
            enable_r         <= 1'b1;
            setting_enable_r <= 1'b0;
            set_hr_or_min_r  <= 1'b0;
            inc_short_r      <= 1'b0;
        end else begin
            if (change_s)       armed_r <= 1'b0;
            else if (rise_s[1]) armed_r <= 1'b1;
            else if (fall_s[1]) armed_r <= 1'b0;
            else                armed_r <= armed_r;
            if (long_s[1] || !deb_r[1] || rep_fire_s) rep_cnt_r <= '0;
            else if (long_done_r[1])                  rep_cnt_r <= rep_cnt_r + RW'(1);
            else                                      rep_cnt_r <= rep_cnt_r;
            enable_r         <= enable_s;
            setting_enable_r <= setting_enable_s;
            set_hr_or_min_r  <= set_hr_or_min_s;
            inc_short_r      <= inc_pulse_s;
        end
    end

    assign bus.enable         = enable_r;
    assign bus.setting_enable = setting_enable_r;
    assign bus.set_hr_or_min  = set_hr_or_min_r;
    assign bus.inc_short      = inc_short_r;
endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench: expected mode changes and inc pulses (by edge number) are queued
// when a button press is driven and matched against the outputs as they appear.
module tb_time_set_controller;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   exp_st = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_out;
    logic [2:0] cur_out;
    logic prev_inc;
    int   pulse_q[$];
    int   mode_cyc_q[$];
    int   mode_val_q[$];

    time_set_if bus ();

    time_set_controller #(
        .DEBOUNCE_TICKS (D),
        .LONG_TICKS     (L),
        .REPEAT_TICKS   (R)
    ) dut (
        .clk_10000Hz (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: value n after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int outs_of(input int st);
        case (st)
            1:       return 3'b010;
            2:       return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    task automatic push_mode(input int c, input int st);
        mode_cyc_q.push_back(c);
        mode_val_q.push_back(outs_of(st));
        exp_st = st;
    endtask

    // Raw mode press held for n edges; queues the state change the press must cause
    task automatic press_mode(input int n);
        int k;
        int f;
        @(negedge clk);
        bus.btn_mode = 1'b1;
        k = cyc + 1;
        f = k + n + D + 1;
        if (n >= D) begin
            if (f >= k + 1 + D + L) push_mode(k + 3 + D + L, (exp_st == 0) ? 1 : 0);
            else if (exp_st != 0)   push_mode(f + 3, (exp_st == 1) ? 2 : 1);
        end
        repeat (n) @(negedge clk);
        bus.btn_mode = 1'b0;
        repeat (D + 12) @(negedge clk);
    endtask

    // Raw inc press held for n edges; live=1 means the press should produce pulses
    task automatic press_inc(input int n, input bit live);
        int k;
        int f;
        int p0;
        @(negedge clk);
        bus.btn_inc = 1'b1;
        k = cyc + 1;
        f = k + n + D + 1;
        p0 = k + D + 2;
        if (live && n >= D) begin
            pulse_q.push_back(p0);
            if (p0 + L <= f + 1) begin
                pulse_q.push_back(p0 + L);
                for (int p = p0 + L + R; p <= f; p += R) pulse_q.push_back(p);
            end
        end
        repeat (n) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (D + 12) @(negedge clk);
    endtask

    // Output monitor: every change and every pulse must match the head of its queue
    always @(negedge clk) begin
        if (mon_en) begin
            cur_out = {bus.enable, bus.setting_enable, bus.set_hr_or_min};
            if (cur_out != prev_out) begin
                if (mode_cyc_q.size() == 0) begin
                    chk("mode_unexpected", int'(cur_out), int'(prev_out));
                end else begin
                    chk("mode_cyc", cyc, mode_cyc_q.pop_front());
                    chk("mode_val", int'(cur_out), mode_val_q.pop_front());
                end
                prev_out = cur_out;
            end
            if (bus.inc_short) begin
                if (pulse_q.size() == 0) chk("pulse_unexpected", cyc, -1);
                else                     chk("pulse_cyc", cyc, pulse_q.pop_front());
                chk("pulse_width", int'(prev_inc), 0);
            end
            prev_inc = bus.inc_short;
        end
    end

    initial begin
        int k;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_enable", int'(bus.enable), 1);
        chk("rst_setting", int'(bus.setting_enable), 0);
        chk("rst_hrmin", int'(bus.set_hr_or_min), 0);
        chk("rst_inc", int'(bus.inc_short), 0);
        prev_out = 3'b100;
        prev_inc = 1'b0;
        exp_st   = 0;
        mon_en   = 1'b1;

        // Glitch shorter than the debounce window
        press_mode(3);
        chk("glitch_enable", int'(bus.enable), 1);
        chk("glitch_setting", int'(bus.setting_enable), 0);

        // Mode walk with a short increment in SET_HR
        press_mode(30);
        press_inc(10, 1'b1);
        press_mode(10);
        press_mode(10);
        press_mode(30);
        chk("walk_enable", int'(bus.enable), 1);

        // Increment ignored in RUN
        press_inc(10, 1'b0);

        // Auto-repeat in SET_MIN
        press_mode(30);
        press_mode(10);
        chk("min_hrmin", int'(bus.set_hr_or_min), 1);
        press_inc(60, 1'b1);
        press_mode(30);

        // Inc held across entry into SET_HR stays disarmed until re-pressed
        @(negedge clk);
        bus.btn_inc = 1'b1;
        press_mode(30);
        repeat (30) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (D + 12) @(negedge clk);
        press_inc(10, 1'b1);

        // Reset during auto-repeat in SET_MIN
        press_mode(10);
        @(negedge clk);
        bus.btn_inc = 1'b1;
        k = cyc + 1;
        pulse_q.push_back(k + D + 2);
        pulse_q.push_back(k + D + 2 + L);
        pulse_q.push_back(k + D + 2 + L + R);
        while (cyc < k + 35) @(negedge clk);
        rst_n = 1'b0;
        push_mode(k + 36, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_inc", int'(bus.inc_short), 0);
        chk("midrst_enable", int'(bus.enable), 1);
        chk("midrst_setting", int'(bus.setting_enable), 0);
        repeat (40) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (D + 12) @(negedge clk);

        chk("pulse_q_left", pulse_q.size(), 0);
        chk("mode_q_left", mode_cyc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
